// File: rtl/cpu_wb_bridge_pkg.sv
// Shared definitions for the CPU-to-Wishbone bridge: FSM state encoding,
// byte-lane select constants and a helper that classifies unaligned words.
package cpu_wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CYC1 = 2'd1,
      CYC2 = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] SEL_LO = 2'b01;
   localparam logic [1:0] SEL_HI = 2'b10;
   localparam logic [1:0] SEL_W  = 2'b11;

   // A word access at an odd byte address straddles two bus words and has
   // to be split into a high-lane byte cycle followed by a low-lane one.
   function automatic logic isUnaligned(input logic byteAcc, input logic adr0);
      return !byteAcc && adr0;
   endfunction

endpackage

// File: rtl/cpu_wb_bridge_if.sv
// Bundle of the core request signals and the Wishbone bus signals seen by
// the bridge. The master modport is the bridge itself; the slave modport is
// the environment (core plus fabric) that drives the requests and acks.
interface cpu_wb_bridge_if;
   import cpu_wb_pkg::*;

   logic [19:0] cpu_adr_i;
   logic [15:0] cpu_dat_i;
   logic [15:0] cpu_dat_o;
   logic        cpu_byte_i;
   logic        cpu_mem_op_i;
   logic        cpu_m_io_i;
   logic        cpu_we_i;
   logic        cpu_block;

   logic [18:0] wb_adr_o;
   logic [1:0]  wb_sel_o;
   logic [15:0] wb_dat_o;
   logic [15:0] wb_dat_i;
   logic        wb_we_o;
   logic        wb_tgc_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i;

   modport master (
      input  cpu_adr_i, cpu_dat_i, cpu_byte_i, cpu_mem_op_i, cpu_m_io_i, cpu_we_i,
      output cpu_dat_o, cpu_block,
      output wb_adr_o, wb_sel_o, wb_dat_o, wb_we_o, wb_tgc_o, wb_cyc_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      output cpu_adr_i, cpu_dat_i, cpu_byte_i, cpu_mem_op_i, cpu_m_io_i, cpu_we_i,
      input  cpu_dat_o, cpu_block,
      input  wb_adr_o, wb_sel_o, wb_dat_o, wb_we_o, wb_tgc_o, wb_cyc_o, wb_stb_o,
      output wb_dat_i, wb_ack_i
   );

endinterface

// File: rtl/cpu_wb_bridge_lane.sv
// Byte-lane steering for the bridge. The write side picks the lane enables
// and replicated write data for the bus cycle about to start; the read side
// folds the bus read data into the assembled result for the cycle that is
// being acknowledged. The two sides are fed independently because the top
// prepares the next cycle while the current one is being captured.
module cpu_wb_lane
   import cpu_wb_pkg::*;
(
   input  logic        wrAdr0_i,
   input  logic        wrByte_i,
   input  logic        wrPhase2_i,
   input  logic [15:0] wrDat_i,
   output logic [1:0]  wrSel_o,
   output logic [15:0] wrDat_o,

   input  logic        rdAdr0_i,
   input  logic        rdByte_i,
   input  logic        rdPhase2_i,
   input  logic [15:0] rdBus_i,
   input  logic [15:0] rdCur_i,
   output logic [15:0] rdNext_o
);

   // Write lanes: single bytes are replicated onto both lanes so the slave
   // can take them from whichever lane sel enables; the second half of a
   // split word carries the core's high byte on the low lane.
   always_comb begin
      wrSel_o = SEL_W;
      wrDat_o = wrDat_i;
      if (wrPhase2_i) begin
         wrSel_o = SEL_LO;
         wrDat_o = {wrDat_i[15:8], wrDat_i[15:8]};
      end else if (wrByte_i) begin
         wrSel_o = wrAdr0_i ? SEL_HI : SEL_LO;
         wrDat_o = {wrDat_i[7:0], wrDat_i[7:0]};
      end else if (wrAdr0_i) begin
         wrSel_o = SEL_HI;
         wrDat_o = {wrDat_i[7:0], wrDat_i[7:0]};
      end
   end

   // Read assembly: a byte read is zero-extended from its lane, a split word
   // collects the high lane of the first word as the low result byte and the
   // low lane of the second word as the high result byte.
   always_comb begin
      rdNext_o = rdBus_i;
      if (rdPhase2_i) begin
         rdNext_o = {rdBus_i[7:0], rdCur_i[7:0]};
      end else if (rdByte_i) begin
         rdNext_o = {8'h00, (rdAdr0_i ? rdBus_i[15:8] : rdBus_i[7:0])};
      end else if (rdAdr0_i) begin
         rdNext_o = {rdCur_i[15:8], rdBus_i[15:8]};
      end
   end

endmodule

// File: rtl/cpu_wb_bridge.sv
// Bridge from the core's memory-request handshake to a 16-bit Wishbone
// classic master. The core is stalled through cpu_block while one bus
// cycle (or two, for an unaligned word) runs; read data is assembled into
// a register that stays visible to the core until the next read capture.
module cpu_wb_bridge
   import cpu_wb_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   cpu_wb_bridge_if.master bus
);

   state_t      state_q, state_d;

   logic [19:0] adr_q, adr_d;
   logic [15:0] dat_q, dat_d;
   logic        byte_q, byte_d;
   logic        we_q, we_d;
   logic        mio_q, mio_d;

   logic [15:0] rdData_q, rdData_d;

   logic [18:0] wbAdr_q, wbAdr_d;
   logic [1:0]  wbSel_q, wbSel_d;
   logic [15:0] wbDat_q, wbDat_d;
   logic        wbWe_q, wbWe_d;
   logic        wbTgc_q, wbTgc_d;
   logic        wbCyc_q, wbCyc_d;

   logic        cpuBlock;

   logic        laneAdr0;
   logic        laneByte;
   logic [15:0] laneDat;
   logic [1:0]  laneSelOut;
   logic [15:0] laneDatOut;
   logic [15:0] laneRdOut;
   logic [18:0] secondWord;

   // In IDLE the first bus cycle is prepared straight from the core's
   // inputs because the request fields are being latched on the same edge.
   assign laneAdr0 = (state_q == IDLE) ? bus.cpu_adr_i[0] : adr_q[0];
   assign laneByte = (state_q == IDLE) ? bus.cpu_byte_i   : byte_q;
   assign laneDat  = (state_q == IDLE) ? bus.cpu_dat_i    : dat_q;

   // The second cycle only exists for an odd byte address, so its word is
   // simply the next word index, wrapping at the top of the address space.
   assign secondWord = adr_q[19:1] + 19'd1;

   cpu_wb_lane lane (
      .wrAdr0_i   (laneAdr0),
      .wrByte_i   (laneByte),
      .wrPhase2_i (state_q != IDLE),
      .wrDat_i    (laneDat),
      .wrSel_o    (laneSelOut),
      .wrDat_o    (laneDatOut),
      .rdAdr0_i   (adr_q[0]),
      .rdByte_i   (byte_q),
      .rdPhase2_i (state_q == CYC2),
      .rdBus_i    (bus.wb_dat_i),
      .rdCur_i    (rdData_q),
      .rdNext_o   (laneRdOut)
   );

   // Next-state logic: accept a request in IDLE, run one or two bus cycles
   // and park in DONE for one cycle so the core sees cpu_block low. Bus
   // outputs are only reloaded on entry to a bus cycle or to DONE.
   always_comb begin
      state_d  = state_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      byte_d   = byte_q;
      we_d     = we_q;
      mio_d    = mio_q;
      rdData_d = rdData_q;
      wbAdr_d  = wbAdr_q;
      wbSel_d  = wbSel_q;
      wbDat_d  = wbDat_q;
      wbWe_d   = wbWe_q;
      wbTgc_d  = wbTgc_q;
      wbCyc_d  = wbCyc_q;
      cpuBlock = 1'b0;

      case (state_q)
         IDLE: begin
            cpuBlock = bus.cpu_mem_op_i;
            if (bus.cpu_mem_op_i) begin
               state_d = CYC1;
               adr_d   = bus.cpu_adr_i;
               dat_d   = bus.cpu_dat_i;
               byte_d  = bus.cpu_byte_i;
               we_d    = bus.cpu_we_i;
               mio_d   = bus.cpu_m_io_i;
               wbAdr_d = bus.cpu_adr_i[19:1];
               wbSel_d = laneSelOut;
               wbDat_d = laneDatOut;
               wbWe_d  = bus.cpu_we_i;
               wbTgc_d = bus.cpu_m_io_i;
               wbCyc_d = 1'b1;
            end
         end

         CYC1: begin
            cpuBlock = 1'b1;
            if (bus.wb_ack_i) begin
               if (!we_q) begin
                  rdData_d = laneRdOut;
               end
               if (isUnaligned(byte_q, adr_q[0])) begin
                  state_d = CYC2;
                  wbAdr_d = secondWord;
                  wbSel_d = laneSelOut;
                  wbDat_d = laneDatOut;
               end else begin
                  state_d = DONE;
                  wbCyc_d = 1'b0;
               end
            end
         end

         CYC2: begin
            cpuBlock = 1'b1;
            if (bus.wb_ack_i) begin
               if (!we_q) begin
                  rdData_d = laneRdOut;
               end
               state_d = DONE;
               wbCyc_d = 1'b0;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            wbCyc_d = 1'b0;
         end
      endcase
   end

   // State register; reset abandons any bus cycle in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request latches, read-data register and registered Wishbone outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         adr_q    <= '0;
         dat_q    <= '0;
         byte_q   <= 1'b0;
         we_q     <= 1'b0;
         mio_q    <= 1'b0;
         rdData_q <= '0;
         wbAdr_q  <= '0;
         wbSel_q  <= '0;
         wbDat_q  <= '0;
         wbWe_q   <= 1'b0;
         wbTgc_q  <= 1'b0;
         wbCyc_q  <= 1'b0;
      end else begin
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         byte_q   <= byte_d;
         we_q     <= we_d;
         mio_q    <= mio_d;
         rdData_q <= rdData_d;
         wbAdr_q  <= wbAdr_d;
         wbSel_q  <= wbSel_d;
         wbDat_q  <= wbDat_d;
         wbWe_q   <= wbWe_d;
         wbTgc_q  <= wbTgc_d;
         wbCyc_q  <= wbCyc_d;
      end
   end

   assign bus.cpu_block = cpuBlock;
   assign bus.cpu_dat_o = rdData_q;
   assign bus.wb_adr_o  = wbAdr_q;
   assign bus.wb_sel_o  = wbSel_q;
   assign bus.wb_dat_o  = wbDat_q;
   assign bus.wb_we_o   = wbWe_q;
   assign bus.wb_tgc_o  = wbTgc_q;
   assign bus.wb_cyc_o  = wbCyc_q;
   assign bus.wb_stb_o  = wbCyc_q;

endmodule

// File: tb/tb_cpu_wb_bridge.sv
// Testbench for cpu_wb_bridge: a Wishbone slave with byte memory and
// configurable wait states, a core-level reference model of memory and
// read results, directed scenarios and a randomized request mix.
module tb_cpu_wb_bridge;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cpu_wb_bridge_if bus ();

   cpu_wb_bridge dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [18:0] adr;
      logic [1:0]  sel;
      logic [15:0] dat;
      logic        we;
      logic        tgc;
   } busRec_t;

   int checks = 0;
   int errors = 0;

   bit [7:0] slaveMem [1048576];
   bit [7:0] refMem   [1048576];

   busRec_t     busLog[$];
   int          fixedWaits = 0;
   int          waitAccum  = 0;
   int          waitsLeft  = 0;
   bit          inCycle    = 1'b0;
   bit          strayAck   = 1'b0;
   logic [15:0] lastResult = 16'h0000;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Slave: decides ack away from the clock edge, keeps its own byte memory
   // and logs every acknowledged bus cycle.
   always @(negedge clk) begin
      busRec_t rec;
      checkOutput("stb_equals_cyc", {31'd0, bus.wb_stb_o}, {31'd0, bus.wb_cyc_o});
      if (!bus.wb_cyc_o) begin
         bus.wb_ack_i = strayAck;
         bus.wb_dat_i = 16'($urandom);
         inCycle      = 1'b0;
      end else begin
         if (!inCycle || bus.wb_ack_i) begin
            inCycle   = 1'b1;
            waitsLeft = (fixedWaits >= 0) ? fixedWaits : int'($urandom_range(0, 2));
            waitAccum += waitsLeft;
            bus.wb_ack_i = 1'b0;
         end
         if (waitsLeft == 0) begin
            bus.wb_dat_i = {slaveMem[{bus.wb_adr_o, 1'b1}], slaveMem[{bus.wb_adr_o, 1'b0}]};
            if (bus.wb_we_o) begin
               if (bus.wb_sel_o[0]) slaveMem[{bus.wb_adr_o, 1'b0}] = bus.wb_dat_o[7:0];
               if (bus.wb_sel_o[1]) slaveMem[{bus.wb_adr_o, 1'b1}] = bus.wb_dat_o[15:8];
            end
            rec.adr = bus.wb_adr_o;
            rec.sel = bus.wb_sel_o;
            rec.dat = bus.wb_dat_o;
            rec.we  = bus.wb_we_o;
            rec.tgc = bus.wb_tgc_o;
            busLog.push_back(rec);
            bus.wb_ack_i = 1'b1;
         end else begin
            waitsLeft--;
            bus.wb_dat_i = 16'($urandom);
            bus.wb_ack_i = 1'b0;
         end
      end
   end

   task automatic preload(input logic [19:0] adr, input logic [7:0] val);
      slaveMem[adr] = val;
      refMem[adr]   = val;
   endtask

   // One core request, started at a falling edge in IDLE; returns at the
   // falling edge of the following IDLE cycle with the request dropped.
   task automatic applyStimulus(input logic [19:0] adr, input logic [15:0] dat,
                                input logic byt, input logic we, input logic mio,
                                input string tag, output int blockCycles);
      logic [19:0] adrNext;
      logic [15:0] expData;
      int          splitWord;
      bit          done;
      adrNext   = adr + 20'd1;
      splitWord = (!byt && adr[0]) ? 1 : 0;
      if (we) begin
         refMem[adr] = dat[7:0];
         if (!byt) refMem[adrNext] = dat[15:8];
         expData = lastResult;
      end else if (byt) begin
         expData = {8'h00, refMem[adr]};
      end else begin
         expData = {refMem[adrNext], refMem[adr]};
      end
      busLog.delete();
      waitAccum        = 0;
      bus.cpu_adr_i    = adr;
      bus.cpu_dat_i    = dat;
      bus.cpu_byte_i   = byt;
      bus.cpu_we_i     = we;
      bus.cpu_m_io_i   = mio;
      bus.cpu_mem_op_i = 1'b1;
      blockCycles      = 0;
      done             = 1'b0;
      for (int i = 0; i < 80; i++) begin
         #1;
         if (!bus.cpu_block) begin
            done = 1'b1;
            break;
         end
         blockCycles++;
         @(negedge clk);
      end
      checkOutput({tag, "/completed"}, {31'd0, done}, 32'd1);
      checkOutput({tag, "/latency"}, blockCycles, 2 + splitWord + waitAccum);
      checkOutput({tag, "/cpu_dat_o"}, {16'd0, bus.cpu_dat_o}, {16'd0, expData});
      checkOutput({tag, "/bus_cycles"}, busLog.size(), 1 + splitWord);
      lastResult       = expData;
      bus.cpu_mem_op_i = 1'b0;
      bus.cpu_adr_i    = 20'($urandom);
      bus.cpu_dat_i    = 16'($urandom);
      @(negedge clk);
   endtask

   task automatic checkLog(input string tag, input int idx, input logic [18:0] adr,
                           input logic [1:0] sel, input logic [15:0] dat,
                           input logic we, input logic tgc, input bit checkDat);
      if (busLog.size() > idx) begin
         checkOutput({tag, "/adr"}, {13'd0, busLog[idx].adr}, {13'd0, adr});
         checkOutput({tag, "/sel"}, {30'd0, busLog[idx].sel}, {30'd0, sel});
         if (checkDat) checkOutput({tag, "/dat"}, {16'd0, busLog[idx].dat}, {16'd0, dat});
         checkOutput({tag, "/we"},  {31'd0, busLog[idx].we},  {31'd0, we});
         checkOutput({tag, "/tgc"}, {31'd0, busLog[idx].tgc}, {31'd0, tgc});
      end else begin
         checkOutput({tag, "/present"}, busLog.size(), idx + 1);
      end
   endtask

   initial begin
      int          lat;
      logic [19:0] a;
      logic        rw, rb, rm;
      rst              = 1'b0;
      bus.cpu_adr_i    = '0;
      bus.cpu_dat_i    = '0;
      bus.cpu_byte_i   = 1'b0;
      bus.cpu_we_i     = 1'b0;
      bus.cpu_m_io_i   = 1'b0;
      bus.cpu_mem_op_i = 1'b0;
      bus.wb_ack_i     = 1'b0;
      bus.wb_dat_i     = '0;

      // Reset values, and cpu_block following the request during reset.
      repeat (3) @(negedge clk);
      checkOutput("rst/cpu_dat_o", {16'd0, bus.cpu_dat_o}, 32'd0);
      checkOutput("rst/cyc",  {31'd0, bus.wb_cyc_o}, 32'd0);
      checkOutput("rst/stb",  {31'd0, bus.wb_stb_o}, 32'd0);
      checkOutput("rst/we",   {31'd0, bus.wb_we_o},  32'd0);
      checkOutput("rst/tgc",  {31'd0, bus.wb_tgc_o}, 32'd0);
      checkOutput("rst/sel",  {30'd0, bus.wb_sel_o}, 32'd0);
      checkOutput("rst/adr",  {13'd0, bus.wb_adr_o}, 32'd0);
      checkOutput("rst/dat",  {16'd0, bus.wb_dat_o}, 32'd0);
      checkOutput("rst/block_low", {31'd0, bus.cpu_block}, 32'd0);
      bus.cpu_mem_op_i = 1'b1;
      #1;
      checkOutput("rst/block_follows", {31'd0, bus.cpu_block}, 32'd1);
      bus.cpu_mem_op_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Aligned word read.
      fixedWaits = 0;
      preload(20'h00400, 8'hEF);
      preload(20'h00401, 8'hBE);
      applyStimulus(20'h00400, 16'h0000, 1'b0, 1'b0, 1'b0, "t1", lat);
      checkOutput("t1/block2", lat, 2);
      checkOutput("t1/data", {16'd0, bus.cpu_dat_o}, 32'h0000BEEF);
      checkLog("t1/c0", 0, 19'h00200, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Byte write on the high lane; the read result must not change.
      applyStimulus(20'h00401, 16'h1234, 1'b1, 1'b1, 1'b0, "t2", lat);
      checkLog("t2/c0", 0, 19'h00200, 2'b10, 16'h3434, 1'b1, 1'b0, 1'b1);
      checkOutput("t2/data_kept", {16'd0, bus.cpu_dat_o}, 32'h0000BEEF);

      // Unaligned word read split across words 0x201 and 0x202.
      preload(20'h00402, 8'h00);
      preload(20'h00403, 8'hAB);
      preload(20'h00404, 8'hCD);
      preload(20'h00405, 8'h00);
      applyStimulus(20'h00403, 16'h0000, 1'b0, 1'b0, 1'b0, "t3", lat);
      checkOutput("t3/block3", lat, 3);
      checkOutput("t3/data", {16'd0, bus.cpu_dat_o}, 32'h0000CDAB);
      checkLog("t3/c0", 0, 19'h00201, 2'b10, 16'h0000, 1'b0, 1'b0, 1'b0);
      checkLog("t3/c1", 1, 19'h00202, 2'b01, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Unaligned word write at the top of the address space wraps to 0.
      applyStimulus(20'hFFFFF, 16'h5678, 1'b0, 1'b1, 1'b0, "t4", lat);
      checkLog("t4/c0", 0, 19'h7FFFF, 2'b10, 16'h7878, 1'b1, 1'b0, 1'b1);
      checkLog("t4/c1", 1, 19'h00000, 2'b01, 16'h5656, 1'b1, 1'b0, 1'b1);
      applyStimulus(20'hFFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, "t4rd", lat);
      checkOutput("t4rd/data", {16'd0, bus.cpu_dat_o}, 32'h00005678);

      // I/O byte read with four wait states.
      fixedWaits = 4;
      preload(20'h00060, 8'h5A);
      applyStimulus(20'h00060, 16'h0000, 1'b1, 1'b0, 1'b1, "t5", lat);
      checkOutput("t5/block6", lat, 6);
      checkOutput("t5/data", {16'd0, bus.cpu_dat_o}, 32'h0000005A);
      checkLog("t5/c0", 0, 19'h00030, 2'b01, 16'h0000, 1'b0, 1'b1, 1'b0);

      // A stray ack while idle must not start or disturb anything.
      strayAck = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("stray/cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
      checkOutput("stray/data", {16'd0, bus.cpu_dat_o}, {16'd0, lastResult});
      strayAck = 1'b0;
      @(negedge clk);

      // Reset asserted in the middle of a bus cycle.
      fixedWaits       = 20;
      bus.cpu_adr_i    = 20'h00010;
      bus.cpu_byte_i   = 1'b0;
      bus.cpu_we_i     = 1'b0;
      bus.cpu_m_io_i   = 1'b0;
      bus.cpu_mem_op_i = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("mid/cyc_up", {31'd0, bus.wb_cyc_o}, 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("mid/cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
      checkOutput("mid/stb", {31'd0, bus.wb_stb_o}, 32'd0);
      checkOutput("mid/cpu_dat_o", {16'd0, bus.cpu_dat_o}, 32'd0);
      checkOutput("mid/block_follows", {31'd0, bus.cpu_block}, 32'd1);
      bus.cpu_mem_op_i = 1'b0;
      lastResult       = 16'h0000;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      fixedWaits = 0;
      applyStimulus(20'h00403, 16'h0000, 1'b0, 1'b0, 1'b0, "post_rst", lat);
      checkOutput("post_rst/data", {16'd0, bus.cpu_dat_o}, 32'h0000CDAB);

      // Randomized mix in a window straddling the address wrap point.
      for (int i = 0; i < 16; i++) begin
         a = 20'hFFFF8 + 20'(i);
         preload(a, 8'($urandom));
      end
      fixedWaits = -1;
      for (int i = 0; i < 200; i++) begin
         a  = 20'hFFFF8 + 20'($urandom_range(0, 15));
         rw = 1'($urandom);
         rb = 1'($urandom);
         rm = 1'($urandom);
         applyStimulus(a, 16'($urandom), rb, rw, rm, "rand", lat);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_wb_bridge.md
# cpu_wb_bridge

Responder for the core's CPU memory-request interface: accepts the core's address/data/byte/write/io request, holds the core with `cpu_block` while it runs one or two Wishbone classic cycles, and returns read data. Sits between the Zet-style core and the 16-bit Wishbone fabric. Unaligned word accesses are split into two byte cycles.

## Interface
Parameters:
- none. Bus widths are fixed: 20-bit address, 16-bit data.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_adr_i`  in  20  byte address from the core.
- `cpu_dat_i`  in  16  write data from the core; a byte write uses [7:0].
- `cpu_dat_o`  out  16  read data to the core; a byte read returns {8'h00, byte}.
- `cpu_byte_i`  in  1  1 = byte access, 0 = word access.
- `cpu_mem_op_i`  in  1  request valid; held high by the core until `cpu_block` drops.
- `cpu_m_io_i`  in  1  1 = I/O space, 0 = memory space.
- `cpu_we_i`  in  1  1 = write.
- `cpu_block`  out  1  stall to the core; combinational.
- `wb_adr_o`  out  19  word address, byte address [19:1].
- `wb_sel_o`  out  2  byte lane enables; [0] selects [7:0].
- `wb_dat_o`  out  16  write data.
- `wb_dat_i`  in  16  read data.
- `wb_we_o`  out  1  write enable.
- `wb_tgc_o`  out  1  I/O tag; equals the latched `cpu_m_io_i`.
- `wb_cyc_o`  out  1  bus cycle.
- `wb_stb_o`  out  1  strobe; always equal to `wb_cyc_o`.
- `wb_ack_i`  in  1  slave acknowledge.

## Operation
- The FSM has four states: IDLE, CYC1, CYC2, DONE.
- **IDLE**
  - `cpu_block` = `cpu_mem_op_i`.
  - When `cpu_mem_op_i` is high, latch adr, dat, byte, we and m_io, then go to CYC1.
- **CYC1**
  - cyc/stb are high. The first-cycle address is the latched adr.
  - Lane rules:
    - Byte access: `wb_sel_o` = adr[0] ? 2'b10 : 2'b01. Write data is {dat[7:0], dat[7:0]}.
    - Aligned word: `wb_sel_o` = 2'b11. Write data is dat.
    - Unaligned word (byte=0, adr[0]=1): `wb_sel_o` = 2'b10. Write data is {dat[7:0], 8'hxx→dat[7:0]}.
  - On `wb_ack_i`, capture the read byte(s) into the data register.
    - If the access is an unaligned word, go to CYC2.
    - Otherwise go to DONE.
- **CYC2**
  - Address is adr+1, which is even; the address wraps modulo 2^20, so 20'hFFFFF+1 = 20'h00000.
  - `wb_sel_o` = 2'b01. Write data is {dat[15:8], dat[15:8]}.
  - On `wb_ack_i`, capture `wb_dat_i[7:0]` into result [15:8], then go to DONE.
- **DONE**
  - `cpu_block` = 0 and cyc/stb = 0.
  - `cpu_dat_o` holds the assembled result.
  - Next state is always IDLE.
- A read byte comes from lane adr[0] ? [15:8] : [7:0]. For an unaligned word, the first byte comes from [15:8] and becomes result [7:0].
- `cpu_block` is high in CYC1 and CYC2 unconditionally.
- `cpu_dat_o` is registered and holds its value until the next capture.
- Writes leave the data register unchanged.

## Timing
- Reset values: state IDLE, `cpu_dat_o` 16'h0000, `wb_cyc_o`/`wb_stb_o`/`wb_we_o`/`wb_tgc_o` 0, `wb_sel_o` 2'b00, `wb_adr_o` 0, `wb_dat_o` 0.
- During reset, `cpu_block` = `cpu_mem_op_i`.
- Wishbone outputs are registered and change only on state entry.
- Latency with zero wait states, counted from request seen in IDLE to `cpu_block` low:
  - 2 cycles for an aligned access.
  - 3 cycles for an unaligned word.
  - Each extra cycle without `wb_ack_i` adds one cycle.
- Back-to-back requests: if `cpu_mem_op_i` is high in the IDLE cycle after DONE, the new request is accepted there. There is no dead cycle beyond DONE.
- Reset mid-cycle drops cyc/stb asynchronously, abandons the transaction and returns to IDLE. A partial unaligned write is not rolled back.
- An ack arriving outside CYC1/CYC2 is ignored.

## Structure
- Shared package `cpu_wb_pkg`:
  - state encoding (IDLE=2'd0, CYC1=2'd1, CYC2=2'd2, DONE=2'd3);
  - lane-select constants `SEL_LO`/`SEL_HI`/`SEL_W`.
- One sub-module, `cpu_wb_lane`: combinational write-lane steering and read-byte extraction, given adr[0], byte, phase.
- The FSM, latches and data register live in the top.

## Test plan
- Aligned word read at 20'h00400, slave returns 16'hBEEF with ack on the first stb -> `wb_sel_o`=2'b11, `wb_adr_o`=19'h00200, `cpu_block` high exactly 2 cycles, `cpu_dat_o`=16'hBEEF.
- Byte write, adr 20'h00401, dat 16'h1234 -> `wb_sel_o`=2'b10, `wb_dat_o`=16'h3434, `wb_we_o`=1, `wb_tgc_o`=0.
- Unaligned word read at 20'h00403; slave returns 16'hAB00 at word 0x201, then 16'h00CD at word 0x202 -> two cycles with sel 10 then 01, `cpu_dat_o`=16'hCDAB, `cpu_block` high 3 cycles.
- Unaligned word write at 20'hFFFFF, dat 16'h5678 -> first cycle at word 19'h7FFFF with sel 10 and data 78; second cycle at word 19'h00000 with sel 01 and data 56 (wrap).
- I/O byte read, m_io=1, slave holds ack low 4 cycles -> `wb_tgc_o`=1, `cpu_block` high 6 cycles, then `cpu_dat_o`=16'h00xx (zero-extended).
- Assert `rst` low while in CYC1 -> cyc/stb go low asynchronously, state returns to IDLE, `cpu_dat_o`=0. A request after release completes normally.
